// File: rtl/audio_adc_rx.sv
// audio_adc_rx: I2S receiver for the codec ADC path.
// The codec is clock master, so bclk, adclrck and adcdat are sampled into the
// CLK domain and all decoding happens on synchronized edge strobes. One packed
// {left, right} word is presented per stereo frame with a one-cycle audio_ready.
module audio_adc_rx #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  bclk,
    input  logic                  adclrck,
    input  logic                  adcdat,
    output logic [DATA_WIDTH-1:0] x,
    output logic                  audio_ready,
    output logic                  frame_err
);

    localparam int HALF  = DATA_WIDTH / 2;
    localparam int CNT_W = $clog2(HALF + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LEFT  = 2'd1;
    localparam logic [1:0] RIGHT = 2'd2;

    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   bclk_p;
    logic                   lr_p;

    logic                   bclk_s;
    logic                   lr_s;
    logic                   dat_s;
    logic                   bclk_rise;
    logic                   lr_rise;
    logic                   lr_fall;

    logic [1:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic                   skip;
    logic [HALF-1:0]        left_shift;
    logic [HALF-1:0]        right_shift;
    logic [HALF-1:0]        left_word;
    logic [HALF-1:0]        right_next;

    assign bclk_s     = bclk_sync[SYNC_STAGES-1];
    assign lr_s       = lr_sync[SYNC_STAGES-1];
    assign dat_s      = dat_sync[SYNC_STAGES-1];
    assign bclk_rise  = bclk_s & ~bclk_p;
    assign lr_rise    = lr_s & ~lr_p;
    assign lr_fall    = ~lr_s & lr_p;
    assign right_next = {right_shift[HALF-2:0], dat_s};

    // Bring the codec pins into CLK; data uses the same depth as bclk so it stays aligned.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            dat_sync  <= '0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], adclrck};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], adcdat};
        end
    end

    // Previous-value flops for edge detection on the synchronized clocks.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            bclk_p <= 1'b0;
            lr_p   <= 1'b0;
        end else begin
            bclk_p <= bclk_s;
            lr_p   <= lr_s;
        end
    end

    // Frame FSM: an lr edge always wins over a coincident bclk rise, and that
    // rise is treated as the I2S delay slot, so skip ends up cleared.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            skip        <= 1'b0;
            left_shift  <= '0;
            right_shift <= '0;
            left_word   <= '0;
            x           <= '0;
            audio_ready <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            audio_ready <= 1'b0;
            frame_err   <= 1'b0;
            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
                skip  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (lr_fall) begin
                            state <= LEFT;
                            cnt   <= '0;
                            skip  <= ~bclk_rise;
                        end
                    end
                    LEFT: begin
                        if (lr_rise) begin
                            if (cnt == CNT_FULL) begin
                                left_word <= left_shift;
                                state     <= RIGHT;
                                cnt       <= '0;
                                skip      <= ~bclk_rise;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= IDLE;
                                cnt       <= '0;
                                skip      <= 1'b0;
                            end
                        end else if (bclk_rise) begin
                            if (skip) begin
                                skip <= 1'b0;
                            end else if (cnt < CNT_FULL) begin
                                left_shift <= {left_shift[HALF-2:0], dat_s};
                                cnt        <= cnt + CNT_ONE;
                            end
                        end
                    end
                    RIGHT: begin
                        if (lr_fall) begin
                            if (cnt != CNT_FULL) begin
                                frame_err <= 1'b1;
                            end
                            state <= LEFT;
                            cnt   <= '0;
                            skip  <= ~bclk_rise;
                        end else if (bclk_rise) begin
                            if (skip) begin
                                skip <= 1'b0;
                            end else if (cnt < CNT_FULL) begin
                                right_shift <= right_next;
                                cnt         <= cnt + CNT_ONE;
                                if (cnt == CNT_LAST) begin
                                    x           <= {left_word, right_next};
                                    audio_ready <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        skip  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_adc_rx.sv
// tb_audio_adc_rx: directed I2S frames driven into audio_adc_rx with
// hand-computed expected words, pulse counts and latency.
module tb_audio_adc_rx;

    localparam int DATA_WIDTH  = 32;
    localparam int SYNC_STAGES = 2;

    logic                  CLK;
    logic                  rst;
    logic                  en;
    logic                  bclk;
    logic                  adclrck;
    logic                  adcdat;
    logic [DATA_WIDTH-1:0] x;
    logic                  audio_ready;
    logic                  frame_err;

    int          errors;
    int          checks;
    int          ready_cnt;
    int          err_cnt;
    int          overlap_cnt;
    time         ready_time;
    time         last_rise;
    time         bit16_rise;
    logic [31:0] xq[$];

    audio_adc_rx #(
        .DATA_WIDTH (DATA_WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .CLK        (CLK),
        .rst        (rst),
        .en         (en),
        .bclk       (bclk),
        .adclrck    (adclrck),
        .adcdat     (adcdat),
        .x          (x),
        .audio_ready(audio_ready),
        .frame_err  (frame_err)
    );

    // 50 MHz system clock; posedges at 10 + 20n ns.
    initial begin
        CLK = 1'b0;
        forever #10 CLK = ~CLK;
    end

    // Observe strobes on the falling edge, away from the active edge.
    always @(negedge CLK) begin
        if (audio_ready) begin
            ready_cnt  = ready_cnt + 1;
            ready_time = $time;
            xq.push_back(x);
        end
        if (frame_err) err_cnt = err_cnt + 1;
        if (audio_ready && frame_err) overlap_cnt = overlap_cnt + 1;
    end

    // One 320 ns bclk period (3.125 MHz): lr and data change on the falling edge.
    task automatic bclk_cycle(input logic lr, input logic d);
        bclk    = 1'b0;
        adclrck = lr;
        adcdat  = d;
        #160;
        bclk      = 1'b1;
        last_rise = $time;
        #160;
    endtask

    // Full I2S frame of nbits per channel followed by two idle right-channel bits.
    task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int nbits);
        bclk_cycle(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) bclk_cycle(1'b0, l[nbits-1-i]);
        bclk_cycle(1'b1, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            bclk_cycle(1'b1, r[nbits-1-i]);
            if (i == 15) bit16_rise = last_rise;
        end
        bclk_cycle(1'b1, 1'b0);
        bclk_cycle(1'b1, 1'b0);
    endtask

    task automatic test_reset;
        #40;
        checks++;
        if (x !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_x: got %h expected 00000000", x);
        end
        checks++;
        if (audio_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b expected 0", audio_ready);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_err: got %b expected 0", frame_err);
        end
        rst = 1'b1;
        #100;
    endtask

    task automatic test_nominal;
        int r0, e0;
        r0 = ready_cnt;
        e0 = err_cnt;
        send_frame(24'h1234, 24'hABCD, 16);
        checks++;
        if (ready_cnt - r0 !== 1) begin
            errors++;
            $display("[TB] FAIL nominal_count: got %0d pulses expected 1", ready_cnt - r0);
        end
        checks++;
        if (x !== 32'h1234ABCD) begin
            errors++;
            $display("[TB] FAIL nominal_x: got %h expected 1234abcd", x);
        end
        // Rise lands 7 ns before a posedge; 3rd posedge sees pulse, next negedge samples it.
        checks++;
        if (ready_time - bit16_rise !== 57) begin
            errors++;
            $display("[TB] FAIL nominal_latency: got %0t expected 57", ready_time - bit16_rise);
        end
        checks++;
        if (err_cnt - e0 !== 0) begin
            errors++;
            $display("[TB] FAIL nominal_err: got %0d expected 0", err_cnt - e0);
        end
    endtask

    task automatic test_enable;
        int r0;
        r0 = ready_cnt;
        en = 1'b0;
        send_frame(24'h1111, 24'h2222, 16);
        send_frame(24'h3333, 24'h4444, 16);
        checks++;
        if (ready_cnt - r0 !== 0) begin
            errors++;
            $display("[TB] FAIL enable_off_count: got %0d expected 0", ready_cnt - r0);
        end
        checks++;
        if (x !== 32'h1234ABCD) begin
            errors++;
            $display("[TB] FAIL enable_off_x: got %h expected 1234abcd", x);
        end
        en = 1'b1;
        send_frame(24'h0F0F, 24'hF0F0, 16);
        checks++;
        if (ready_cnt - r0 !== 1) begin
            errors++;
            $display("[TB] FAIL enable_on_count: got %0d expected 1", ready_cnt - r0);
        end
        checks++;
        if (x !== 32'h0F0FF0F0) begin
            errors++;
            $display("[TB] FAIL enable_on_x: got %h expected 0f0ff0f0", x);
        end
    endtask

    task automatic test_long_word;
        int r0;
        r0 = ready_cnt;
        send_frame(24'h123456, 24'hABCDEF, 24);
        checks++;
        if (ready_cnt - r0 !== 1) begin
            errors++;
            $display("[TB] FAIL long_count: got %0d expected 1", ready_cnt - r0);
        end
        checks++;
        if (x !== 32'h1234ABCD) begin
            errors++;
            $display("[TB] FAIL long_x: got %h expected 1234abcd", x);
        end
    endtask

    task automatic test_truncated;
        int r0, e0;
        r0 = ready_cnt;
        e0 = err_cnt;
        bclk_cycle(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) bclk_cycle(1'b0, i[0]);
        bclk_cycle(1'b1, 1'b0);
        for (int i = 0; i < 17; i++) bclk_cycle(1'b1, 1'b1);
        checks++;
        if (err_cnt - e0 !== 1) begin
            errors++;
            $display("[TB] FAIL trunc_err: got %0d expected 1", err_cnt - e0);
        end
        checks++;
        if (ready_cnt - r0 !== 0) begin
            errors++;
            $display("[TB] FAIL trunc_count: got %0d expected 0", ready_cnt - r0);
        end
        send_frame(24'h5A5A, 24'hA5A5, 16);
        checks++;
        if (ready_cnt - r0 !== 1) begin
            errors++;
            $display("[TB] FAIL trunc_recover_count: got %0d expected 1", ready_cnt - r0);
        end
        checks++;
        if (x !== 32'h5A5AA5A5) begin
            errors++;
            $display("[TB] FAIL trunc_recover_x: got %h expected 5a5aa5a5", x);
        end
    endtask

    task automatic test_midframe_start;
        int r0;
        r0 = ready_cnt;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) bclk_cycle(1'b1, 1'b1);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) bclk_cycle(1'b1, i[0]);
        checks++;
        if (ready_cnt - r0 !== 0) begin
            errors++;
            $display("[TB] FAIL midframe_early: got %0d pulses expected 0", ready_cnt - r0);
        end
        checks++;
        if (x !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midframe_x0: got %h expected 00000000", x);
        end
        send_frame(24'hC3C3, 24'h3C3C, 16);
        checks++;
        if (ready_cnt - r0 !== 1) begin
            errors++;
            $display("[TB] FAIL midframe_count: got %0d expected 1", ready_cnt - r0);
        end
        checks++;
        if (x !== 32'hC3C33C3C) begin
            errors++;
            $display("[TB] FAIL midframe_x: got %h expected c3c33c3c", x);
        end
    endtask

    task automatic test_reset_mid_left;
        int r0;
        r0 = ready_cnt;
        bclk_cycle(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) bclk_cycle(1'b0, 1'b1);
        rst = 1'b0;
        #5;
        checks++;
        if (x !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_mid_x: got %h expected 00000000", x);
        end
        checks++;
        if (audio_ready !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid_strobes: got %b%b expected 00", audio_ready, frame_err);
        end
        #155;
        rst = 1'b1;
        for (int i = 0; i < 11; i++) bclk_cycle(1'b0, 1'b1);
        bclk_cycle(1'b1, 1'b0);
        for (int i = 0; i < 18; i++) bclk_cycle(1'b1, 1'b1);
        checks++;
        if (ready_cnt - r0 !== 0) begin
            errors++;
            $display("[TB] FAIL rst_mid_count: got %0d expected 0", ready_cnt - r0);
        end
        checks++;
        if (x !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_mid_hold: got %h expected 00000000", x);
        end
    endtask

    task automatic test_back_to_back;
        int          q0, e0;
        logic [15:0] n16;
        logic [31:0] exp_x;
        q0 = xq.size();
        e0 = err_cnt;
        for (int n = 1; n <= 10; n++) begin
            n16 = 16'(n);
            send_frame({8'h00, n16}, {8'h00, ~n16}, 16);
        end
        checks++;
        if (xq.size() - q0 !== 10) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d expected 10", xq.size() - q0);
        end
        for (int n = 1; n <= 10; n++) begin
            if (q0 + n - 1 < xq.size()) begin
                n16   = 16'(n);
                exp_x = {n16, ~n16};
                checks++;
                if (xq[q0+n-1] !== exp_x) begin
                    errors++;
                    $display("[TB] FAIL b2b_x[%0d]: got %h expected %h", n, xq[q0+n-1], exp_x);
                end
            end
        end
        checks++;
        if (err_cnt - e0 !== 0) begin
            errors++;
            $display("[TB] FAIL b2b_err: got %0d expected 0", err_cnt - e0);
        end
    endtask

    // Stimulus starts 3 ns after a multiple of 20 so pin changes never hit a CLK edge.
    initial begin
        errors      = 0;
        checks      = 0;
        ready_cnt   = 0;
        err_cnt     = 0;
        overlap_cnt = 0;
        ready_time  = 0;
        last_rise   = 0;
        bit16_rise  = 0;
        rst         = 1'b0;
        en          = 1'b1;
        bclk        = 1'b0;
        adclrck     = 1'b1;
        adcdat      = 1'b0;
        #3;
        test_reset;
        test_nominal;
        test_enable;
        test_long_word;
        test_truncated;
        test_midframe_start;
        test_reset_mid_left;
        test_back_to_back;
        checks++;
        if (overlap_cnt !== 0) begin
            errors++;
            $display("[TB] FAIL ready_err_overlap: got %0d expected 0", overlap_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
